// File: rtl/systolic_mac.sv
// -----------------------------------------------------------------------------
// systolic_mac
//
// Multiply-accumulate processing element for a systolic grid. Each valid beat
// multiplies the signed operands arriving from west (Ain) and north (Bin) and
// adds the product into a running accumulator. After K valid beats the sum is
// presented on Cout together with a one-cycle done pulse, and accumulation
// restarts on the very next valid beat. The operands and their valid flag are
// forwarded east/south through one register stage so neighbouring PEs see the
// same skewed stream one beat later.
//
// Parameters:
//   BITS_AB  width of each signed A/B operand
//   BITS_C   width of the signed accumulator and result (>= 2*BITS_AB)
//   K        valid products per result (>= 1)
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset, overrides en and clr
//   en         advance enable, shared with the feeding fifo shift enable
//   clr        synchronous clear of the partial accumulation and ovf
//   valid_in   Ain/Bin carry a real operand pair this beat
//   Ain, Bin   signed operands from west / north
//   valid_out  valid_in delayed one enabled beat
//   Aout, Bout Ain / Bin delayed one enabled beat
//   Cout       last completed result, held until the next one
//   done       one-cycle pulse, Cout has just been updated
//   ovf        sticky saturation flag
//
// Configuration macro:
//   SAT_EN  defined: every accumulate/complete step saturates to the signed
//           BITS_C range and any clipped step sets ovf (sticky until rst/clr).
//           undefined: wrap-around arithmetic, ovf tied to 0.
// -----------------------------------------------------------------------------
module systolic_mac #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int K       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic               valid_in,
    input  logic [BITS_AB-1:0] Ain,
    input  logic [BITS_AB-1:0] Bin,
    output logic               valid_out,
    output logic [BITS_AB-1:0] Aout,
    output logic [BITS_AB-1:0] Bout,
    output logic [BITS_C-1:0]  Cout,
    output logic               done,
    output logic               ovf
);

    // A K of 1 still needs a one-bit counter; it simply never leaves zero.
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    logic signed [2*BITS_AB-1:0] prod;
    logic signed [BITS_C-1:0]    prodExt;
    logic signed [BITS_C-1:0]    acc;
    logic signed [BITS_C-1:0]    sum;
    logic [CW-1:0]               cnt;
    logic                        step;

    assign prod    = $signed(Ain) * $signed(Bin);
    // Size cast of a signed value sign-extends, and also works when
    // BITS_C equals 2*BITS_AB (no zero-width replication).
    assign prodExt = BITS_C'(prod);

    // A counted beat: enabled, carries data, and not overridden by clr.
    assign step = en && valid_in && !clr;

`ifdef SAT_EN
    localparam logic signed [BITS_C-1:0] MAXV = {1'b0, {(BITS_C-1){1'b1}}};
    localparam logic signed [BITS_C-1:0] MINV = {1'b1, {(BITS_C-1){1'b0}}};

    logic signed [BITS_C:0] sumWide;
    logic                   clipped;

    // One guard bit is enough for the sum of two BITS_C signed values; the
    // guard and MSB disagree exactly when the true sum left the range.
    assign sumWide = (BITS_C+1)'(acc) + (BITS_C+1)'(prodExt);

    always_comb begin
        clipped = sumWide[BITS_C] ^ sumWide[BITS_C-1];
        sum     = sumWide[BITS_C-1:0];
        if (clipped) begin
            sum = sumWide[BITS_C] ? MINV : MAXV;
        end
    end

    // Sticky overflow: set by any clipped counted beat, cleared only by
    // rst or clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (step && clipped) begin
            ovf <= 1'b1;
        end
    end
`else
    assign sum = acc + prodExt;
    assign ovf = 1'b0;
`endif

    // Pass-through stage, accumulator/counter and result register. done is
    // cleared every cycle by default so it can never stretch, even while
    // en is low. clr takes priority over a valid beat and discards it.
    always_ff @(posedge clk) begin
        if (rst) begin
            Aout      <= '0;
            Bout      <= '0;
            valid_out <= 1'b0;
            Cout      <= '0;
            done      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            if (en) begin
                Aout      <= Ain;
                Bout      <= Bin;
                valid_out <= valid_in;
            end
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (step) begin
                if (cnt == LAST) begin
                    Cout <= sum;
                    done <= 1'b1;
                    acc  <= '0;
                    cnt  <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_mac.sv
// -----------------------------------------------------------------------------
// tb_systolic_mac
//
// Self-checking bench for systolic_mac with BITS_AB=8, BITS_C=16, K=4.
// A table of directed vectors (inputs plus hand-computed outputs expected
// after the following rising edge) is applied one per cycle, followed by a
// hand-written saturation / done-pulse sequence. Expected values that depend
// on the SAT_EN build option are selected with the same macro.
// -----------------------------------------------------------------------------
module tb_systolic_mac;

    localparam logic SAT =
`ifdef SAT_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic        clr;
    logic        valid_in;
    logic [7:0]  Ain;
    logic [7:0]  Bin;
    logic        valid_out;
    logic [7:0]  Aout;
    logic [7:0]  Bout;
    logic [15:0] Cout;
    logic        done;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    systolic_mac #(
        .BITS_AB(8),
        .BITS_C (16),
        .K      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .valid_in (valid_in),
        .Ain      (Ain),
        .Bin      (Bin),
        .valid_out(valid_out),
        .Aout     (Aout),
        .Bout     (Bout),
        .Cout     (Cout),
        .done     (done),
        .ovf      (ovf)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        clr;
        logic        vld;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  expA;
        logic [7:0]  expB;
        logic        expV;
        logic [15:0] expC;
        logic        expDone;
        logic        expOvf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic e, input logic c,
                                input logic v, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] ea,
                                input logic [7:0] eb, input logic ev,
                                input logic [15:0] ec, input logic ed,
                                input logic eo);
        vec_t t;
        t.rst = r;  t.en = e;   t.clr = c;  t.vld = v;
        t.a = a;    t.b = b;    t.expA = ea; t.expB = eb;
        t.expV = ev; t.expC = ec; t.expDone = ed; t.expOvf = eo;
        return t;
    endfunction

    // Compare one output against its expected value and keep the tallies.
    task automatic checkOne(input string name, input logic [15:0] act,
                            input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a vector's inputs, then let one rising edge pass and settle.
    task automatic applyStimulus(input vec_t t);
        rst      = t.rst;
        en       = t.en;
        clr      = t.clr;
        valid_in = t.vld;
        Ain      = t.a;
        Bin      = t.b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx, input vec_t t);
        checkOne($sformatf("vec%0d Aout", idx), {8'h00, Aout}, {8'h00, t.expA});
        checkOne($sformatf("vec%0d Bout", idx), {8'h00, Bout}, {8'h00, t.expB});
        checkOne($sformatf("vec%0d valid_out", idx), {15'h0, valid_out}, {15'h0, t.expV});
        checkOne($sformatf("vec%0d Cout", idx), Cout, t.expC);
        checkOne($sformatf("vec%0d done", idx), {15'h0, done}, {15'h0, t.expDone});
        checkOne($sformatf("vec%0d ovf", idx), {15'h0, ovf}, {15'h0, t.expOvf});
    endtask

    initial begin
        int waited;
        logic [15:0] satC;

        rst = 1'b1; en = 1'b0; clr = 1'b0; valid_in = 1'b0;
        Ain = 8'h00; Bin = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        //                r  e  c  v  A      B      eA     eB     eV  eC                       eD eO
        // reset overrides en/valid
        vecs.push_back(mk(1, 1, 0, 1, 8'h05, 8'h05, 8'h00, 8'h00, 0, 16'h0000, 0, 0));
        // A=1..4, B=2 -> 20
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h02, 8'h01, 8'h02, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h02, 8'h02, 8'h02, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h03, 8'h02, 8'h03, 8'h02, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h04, 8'h02, 8'h04, 8'h02, 1, 16'h0014, 1, 0));
        // -3*5 x4 -> -60, then 1*1 x4 -> 4 with no bubble
        vecs.push_back(mk(0, 1, 0, 1, 8'hFD, 8'h05, 8'hFD, 8'h05, 1, 16'h0014, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'hFD, 8'h05, 8'hFD, 8'h05, 1, 16'h0014, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'hFD, 8'h05, 8'hFD, 8'h05, 1, 16'h0014, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'hFD, 8'h05, 8'hFD, 8'h05, 1, 16'hFFC4, 1, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01, 1, 16'hFFC4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01, 1, 16'hFFC4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01, 1, 16'hFFC4, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01, 1, 16'h0004, 1, 0));
        // 2*2 x4 with bubbles and en=0 cycles -> 16; en=0 freezes pass-through
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h02, 8'h02, 8'h02, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h09, 8'h09, 8'h09, 8'h09, 0, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'h07, 8'h07, 8'h09, 8'h09, 0, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h02, 8'h02, 8'h02, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h03, 8'h03, 8'h02, 8'h02, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h02, 8'h02, 8'h02, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h02, 8'h02, 8'h02, 1, 16'h0010, 1, 0));
        // 127*127 x4: wrap -> 0xFC04, saturate -> 0x7FFF with ovf from beat 3
        vecs.push_back(mk(0, 1, 0, 1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1, 16'h0010, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1, 16'h0010, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1, 16'h0010, 0, SAT));
        satC = SAT ? 16'h7FFF : 16'hFC04;
        vecs.push_back(mk(0, 1, 0, 1, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1, satC,     1, SAT));
        // 2 beats, clr, clr with valid (dropped), then 1*1 x4 -> 4
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01, 1, satC,     0, SAT));
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01, 1, satC,     0, SAT));
        vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, satC,     0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 8'h05, 8'h05, 8'h05, 8'h05, 1, satC,     0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01, 1, satC,     0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01, 1, satC,     0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01, 1, satC,     0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h01, 8'h01, 8'h01, 8'h01, 1, 16'h0004, 1, 0));
        // 3 beats, rst, then 2*3 x4 -> 24; done clears even with en=0
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h03, 8'h02, 8'h03, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h03, 8'h02, 8'h03, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h03, 8'h02, 8'h03, 1, 16'h0004, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 8'h09, 8'h09, 8'h00, 8'h00, 0, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h03, 8'h02, 8'h03, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h03, 8'h02, 8'h03, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h03, 8'h02, 8'h03, 1, 16'h0000, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'h02, 8'h03, 8'h02, 8'h03, 1, 16'h0018, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h02, 8'h03, 1, 16'h0018, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // (-128)*(-128) x4 = 65536: wraps to 0, saturates to 0x7FFF from
        // beat 2. Wait for done with a cycle budget, then confirm the pulse
        // is a single cycle wide.
        $display("[TB] saturation / done-pulse sequence");
        rst = 1'b0; en = 1'b1; clr = 1'b0; valid_in = 1'b1;
        Ain = 8'h80; Bin = 8'h80;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOne("seq ovf before final beat", {15'h0, ovf}, {15'h0, SAT});
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        waited = 0;
        while (!done && waited < 4) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOne("seq done seen within budget", {15'h0, done}, 16'h0001);
        checkOne("seq done latency", 16'(waited), 16'h0000);
        checkOne("seq Cout", Cout, SAT ? 16'h7FFF : 16'h0000);
        @(posedge clk);
        #1;
        checkOne("seq done single cycle", {15'h0, done}, 16'h0000);
        checkOne("seq ovf sticky", {15'h0, ovf}, {15'h0, SAT});

        // clr with en low still clears ovf and keeps Cout.
        en = 1'b0; clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOne("seq clr clears ovf", {15'h0, ovf}, 16'h0000);
        checkOne("seq clr holds Cout", Cout, SAT ? 16'h7FFF : 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
